// File: rtl/csa_pkg.sv
// Shared CSA S-box widths, payload/result types and arbiter state encoding.
package csa_pkg;

  localparam int unsigned CSA_SBOX_IN_W  = 5;
  localparam int unsigned CSA_SBOX_OUT_W = 2;
  localparam int unsigned CSA_NUM_SBOX   = 7;
  localparam int unsigned CSA_PAYLOAD_W  = CSA_SBOX_IN_W * CSA_NUM_SBOX;
  localparam int unsigned CSA_RESULT_W   = CSA_SBOX_OUT_W * CSA_NUM_SBOX;
  localparam int unsigned CSA_SEL_W      = 3;
  localparam int unsigned CSA_SBOX_DEPTH = 32;

  // Element k holds the input to / output of sbox(k+1).
  typedef logic [CSA_NUM_SBOX-1:0][CSA_SBOX_IN_W-1:0]  csa_payload_t;
  typedef logic [CSA_NUM_SBOX-1:0][CSA_SBOX_OUT_W-1:0] csa_result_t;

  typedef enum logic [1:0] {
    CSA_IDLE   = 2'd0,
    CSA_LOOKUP = 2'd1,
    CSA_DONE   = 2'd2
  } csa_state_e;

endpackage

// File: rtl/csa_sbox_bank.sv
// Combinational bank of the seven CSA stream-cipher S-boxes behind one select port.
module csa_sbox_bank
  import csa_pkg::*;
(
  input  logic [CSA_SEL_W-1:0]      sb_sel,
  input  logic [CSA_SBOX_IN_W-1:0]  sb_in,
  output logic [CSA_SBOX_OUT_W-1:0] sb_out
);

  localparam logic [CSA_SBOX_OUT_W-1:0] SBOX [CSA_NUM_SBOX][CSA_SBOX_DEPTH] = '{
    '{2'd2,2'd0,2'd1,2'd1,2'd2,2'd3,2'd3,2'd0, 2'd3,2'd2,2'd2,2'd0,2'd1,2'd1,2'd0,2'd3,
      2'd0,2'd3,2'd3,2'd0,2'd2,2'd2,2'd1,2'd1, 2'd2,2'd2,2'd0,2'd3,2'd1,2'd1,2'd3,2'd0},
    '{2'd3,2'd1,2'd0,2'd2,2'd2,2'd3,2'd3,2'd0, 2'd1,2'd3,2'd2,2'd1,2'd0,2'd0,2'd1,2'd2,
      2'd3,2'd1,2'd0,2'd3,2'd3,2'd2,2'd0,2'd2, 2'd0,2'd0,2'd1,2'd2,2'd2,2'd1,2'd3,2'd1},
    '{2'd2,2'd0,2'd1,2'd2,2'd2,2'd3,2'd3,2'd1, 2'd1,2'd1,2'd0,2'd3,2'd3,2'd0,2'd2,2'd0,
      2'd1,2'd3,2'd0,2'd1,2'd3,2'd0,2'd2,2'd2, 2'd2,2'd0,2'd1,2'd2,2'd0,2'd3,2'd3,2'd1},
    '{2'd3,2'd1,2'd2,2'd3,2'd0,2'd2,2'd1,2'd2, 2'd1,2'd2,2'd0,2'd1,2'd3,2'd0,2'd0,2'd3,
      2'd1,2'd0,2'd3,2'd1,2'd2,2'd3,2'd0,2'd3, 2'd0,2'd3,2'd2,2'd0,2'd1,2'd2,2'd2,2'd1},
    '{2'd2,2'd0,2'd0,2'd1,2'd3,2'd2,2'd3,2'd2, 2'd0,2'd1,2'd3,2'd3,2'd1,2'd0,2'd2,2'd1,
      2'd2,2'd3,2'd2,2'd0,2'd0,2'd3,2'd1,2'd1, 2'd1,2'd0,2'd3,2'd2,2'd3,2'd1,2'd0,2'd2},
    '{2'd0,2'd1,2'd2,2'd3,2'd1,2'd2,2'd2,2'd0, 2'd0,2'd1,2'd3,2'd0,2'd2,2'd3,2'd1,2'd3,
      2'd2,2'd3,2'd0,2'd2,2'd3,2'd0,2'd1,2'd1, 2'd2,2'd1,2'd1,2'd2,2'd0,2'd3,2'd3,2'd0},
    '{2'd0,2'd3,2'd2,2'd2,2'd3,2'd0,2'd0,2'd1, 2'd3,2'd0,2'd1,2'd3,2'd1,2'd2,2'd2,2'd1,
      2'd1,2'd0,2'd3,2'd3,2'd0,2'd1,2'd1,2'd2, 2'd2,2'd3,2'd1,2'd0,2'd2,2'd3,2'd0,2'd2}
  };

  // Select 7 has no S-box behind it and reads as zero.
  always_comb begin
    sb_out = '0;
    if (sb_sel < CSA_SEL_W'(CSA_NUM_SBOX)) begin
      sb_out = SBOX[sb_sel][sb_in];
    end
  end

endmodule

// File: rtl/csa_sbox_arb.sv
// Round-robin arbiter that runs each granted request's seven S-box lookups
// serially through one shared bank port and returns the packed result.
module csa_sbox_arb
  import csa_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned LOOKUPS = 7
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [NUM_REQ*CSA_PAYLOAD_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]                req_ready,
  output logic [NUM_REQ-1:0]                rsp_valid,
  output logic [CSA_RESULT_W-1:0]           rsp_data,
  output logic [CSA_SEL_W-1:0]              sb_sel,
  output logic [CSA_SBOX_IN_W-1:0]          sb_in,
  input  logic [CSA_SBOX_OUT_W-1:0]         sb_out
);

  csa_state_e                 state_q, state_d;
  logic                       ptr_q, ptr_d;
  logic                       owner_q, owner_d;
  logic [CSA_SEL_W-1:0]       k_q, k_d;
  csa_payload_t               payload_q, payload_d;
  csa_result_t                result_q, result_d;
  logic [NUM_REQ-1:0]         rsp_valid_q, rsp_valid_d;
  logic [CSA_RESULT_W-1:0]    rsp_data_q, rsp_data_d;
  logic [CSA_SEL_W-1:0]       sb_sel_q, sb_sel_d;
  logic [CSA_SBOX_IN_W-1:0]   sb_in_q, sb_in_d;
  logic [NUM_REQ-1:0]         req_ready_c;
  logic                       gnt_id;
  csa_payload_t               req_pl0, req_pl1;

  assign req_pl0 = req_data[CSA_PAYLOAD_W-1:0];
  assign req_pl1 = req_data[2*CSA_PAYLOAD_W-1:CSA_PAYLOAD_W];

  // Next-state: grant in IDLE, one lookup per LOOKUP cycle, single-cycle DONE.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    k_d         = k_q;
    payload_d   = payload_q;
    result_d    = result_q;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    req_ready_c = '0;
    gnt_id      = ptr_q;

    case (state_q)
      CSA_IDLE: begin
        if (|req_valid) begin
          gnt_id      = (&req_valid[1:0]) ? ptr_q : ~req_valid[0];
          req_ready_c = NUM_REQ'(1) << gnt_id;
          payload_d   = gnt_id ? req_pl1 : req_pl0;
          owner_d     = gnt_id;
          ptr_d       = ~gnt_id;
          k_d         = '0;
          result_d    = '0;
          state_d     = CSA_LOOKUP;
        end
      end
      CSA_LOOKUP: begin
        result_d[k_q] = sb_out;
        if (k_q == CSA_SEL_W'(LOOKUPS - 1)) begin
          state_d     = CSA_DONE;
          rsp_valid_d = NUM_REQ'(1) << owner_q;
          rsp_data_d  = result_d;
        end else begin
          k_d = k_q + CSA_SEL_W'(1);
        end
      end
      CSA_DONE: begin
        state_d = CSA_IDLE;
      end
      default: begin
        state_d = CSA_IDLE;
      end
    endcase

    // Bank port is registered from next state so it lines up with the LOOKUP cycle.
    sb_sel_d = '0;
    sb_in_d  = '0;
    if (state_d == CSA_LOOKUP) begin
      sb_sel_d = k_d;
      sb_in_d  = payload_d[k_d];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= CSA_IDLE;
      ptr_q       <= 1'b0;
      owner_q     <= 1'b0;
      k_q         <= '0;
      payload_q   <= '0;
      result_q    <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      sb_sel_q    <= '0;
      sb_in_q     <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      k_q         <= k_d;
      payload_q   <= payload_d;
      result_q    <= result_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      sb_sel_q    <= sb_sel_d;
      sb_in_q     <= sb_in_d;
    end
  end

  // Accept strobe is combinational so the grant lands in the IDLE cycle itself.
  assign req_ready = req_ready_c;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign sb_sel    = sb_sel_q;
  assign sb_in     = sb_in_q;

endmodule

// File: tb/tb_csa_sbox_arb.sv
// Self-checking bench for csa_sbox_arb with the S-box bank wired beside it.
module tb_csa_sbox_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [69:0] req_data;
  logic [1:0]  req_ready;
  logic [1:0]  rsp_valid;
  logic [13:0] rsp_data;
  logic [2:0]  sb_sel;
  logic [4:0]  sb_in;
  logic [1:0]  sb_out;
  logic [2:0]  probe_sel;
  logic [4:0]  probe_in;
  logic [1:0]  probe_out;

  always #5 clk = ~clk;

  csa_sbox_arb #(.NUM_REQ(2), .LOOKUPS(7)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .sb_sel(sb_sel), .sb_in(sb_in), .sb_out(sb_out)
  );

  csa_sbox_bank u_bank (.sb_sel(sb_sel), .sb_in(sb_in), .sb_out(sb_out));
  csa_sbox_bank u_probe (.sb_sel(probe_sel), .sb_in(probe_in), .sb_out(probe_out));

  // CSA stream-cipher S-box tables, indexed [sbox-1][input].
  int sbox_ref [7][32] = '{
    '{2,0,1,1,2,3,3,0, 3,2,2,0,1,1,0,3, 0,3,3,0,2,2,1,1, 2,2,0,3,1,1,3,0},
    '{3,1,0,2,2,3,3,0, 1,3,2,1,0,0,1,2, 3,1,0,3,3,2,0,2, 0,0,1,2,2,1,3,1},
    '{2,0,1,2,2,3,3,1, 1,1,0,3,3,0,2,0, 1,3,0,1,3,0,2,2, 2,0,1,2,0,3,3,1},
    '{3,1,2,3,0,2,1,2, 1,2,0,1,3,0,0,3, 1,0,3,1,2,3,0,3, 0,3,2,0,1,2,2,1},
    '{2,0,0,1,3,2,3,2, 0,1,3,3,1,0,2,1, 2,3,2,0,0,3,1,1, 1,0,3,2,3,1,0,2},
    '{0,1,2,3,1,2,2,0, 0,1,3,0,2,3,1,3, 2,3,0,2,3,0,1,1, 2,1,1,2,0,3,3,0},
    '{0,3,2,2,3,0,0,1, 3,0,1,3,1,2,2,1, 1,0,3,3,0,1,1,2, 2,3,1,0,2,3,0,2}
  };

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [13:0] golden(input logic [34:0] p);
    logic [13:0] g;
    g = '0;
    for (int k = 0; k < 7; k++) g[2*k +: 2] = 2'(sbox_ref[k][p[5*k +: 5]]);
    return g;
  endfunction

  function automatic logic [34:0] rnd35();
    return 35'({$urandom(), $urandom()});
  endfunction

  // Reference model: phase 0 idle, 1..7 lookup of slice phase-1, 8 response.
  int          m_phase = 0;
  int          m_ptr = 0;
  int          m_owner = 0;
  logic [34:0] m_payload = '0;
  logic [13:0] m_last = '0;

  bit          rst_drv = 1'b0;
  bit [1:0]    pend = '0;
  logic [34:0] pdata [2];
  bit          auto_rep = 1'b0;
  bit          rand_mode = 1'b0;
  int          cyc = 0;
  int          grant_id [$];
  int          grant_cyc [$];
  int          rsp_owner [$];
  int          rsp_cnt = 0;
  int          rsp_cyc_last = 0;
  logic [13:0] rsp_seen = '0;

  function automatic int gid(input int i);
    return (i < grant_id.size()) ? grant_id[i] : -1;
  endfunction

  function automatic int gcyc(input int i);
    return (i < grant_cyc.size()) ? grant_cyc[i] : -1000;
  endfunction

  function automatic int rown(input int i);
    return (i < rsp_owner.size()) ? rsp_owner[i] : -1;
  endfunction

  task automatic cycle();
    int          win;
    logic [1:0]  e_rdy, e_rv;
    logic [2:0]  e_sel;
    logic [4:0]  e_in;
    logic [13:0] e_data;
    rst_n     = rst_drv;
    req_valid = pend;
    for (int r = 0; r < 2; r++) req_data[35*r +: 35] = pend[r] ? pdata[r] : rnd35();
    @(negedge clk);
    cyc++;
    win   = 0;
    e_rdy = '0;
    if (m_phase == 0 && req_valid != 2'b00) begin
      win   = (req_valid == 2'b11) ? m_ptr : (req_valid[0] ? 0 : 1);
      e_rdy = 2'(1 << win);
    end
    e_sel = '0;
    e_in  = '0;
    if (m_phase >= 1 && m_phase <= 7) begin
      e_sel = 3'(m_phase - 1);
      e_in  = m_payload[5*(m_phase-1) +: 5];
    end
    e_rv   = (m_phase == 8) ? 2'(1 << m_owner) : 2'b00;
    e_data = (m_phase == 8) ? golden(m_payload) : m_last;
    chk("req_ready", 64'(req_ready), 64'(e_rdy));
    chk("sb_sel", 64'(sb_sel), 64'(e_sel));
    chk("sb_in", 64'(sb_in), 64'(e_in));
    chk("rsp_valid", 64'(rsp_valid), 64'(e_rv));
    chk("rsp_data", 64'(rsp_data), 64'(e_data));
    if (rsp_valid != 2'b00) begin
      rsp_cnt++;
      rsp_cyc_last = cyc;
      rsp_seen     = rsp_data;
      rsp_owner.push_back(rsp_valid[1] ? 1 : 0);
    end
    if (!rst_n) begin
      m_phase = 0;
      m_ptr   = 0;
      m_last  = '0;
    end else if (m_phase == 0) begin
      if (req_valid != 2'b00) begin
        m_owner   = win;
        m_payload = req_data[35*win +: 35];
        m_ptr     = 1 - win;
        m_phase   = 1;
      end
    end else if (m_phase == 8) begin
      m_last  = golden(m_payload);
      m_phase = 0;
    end else begin
      m_phase++;
    end
    if (rst_n) begin
      for (int r = 0; r < 2; r++) begin
        if (pend[r] && req_ready[r]) begin
          pend[r] = 1'b0;
          grant_id.push_back(r);
          grant_cyc.push_back(cyc);
          if (auto_rep) begin
            pend[r]  = 1'b1;
            pdata[r] = rnd35();
          end
        end
      end
    end
    if (rand_mode) begin
      for (int r = 0; r < 2; r++) begin
        if (!pend[r] && $urandom_range(0, 3) == 0) begin
          pend[r]  = 1'b1;
          pdata[r] = rnd35();
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_single(input int r, input logic [34:0] p, output logic [13:0] d, output int lat);
    int n0 = grant_cyc.size();
    int r0 = rsp_cnt;
    pend[r]  = 1'b1;
    pdata[r] = p;
    for (int i = 0; i < 30 && rsp_cnt == r0; i++) cycle();
    chk("single_rsp_count", 64'(rsp_cnt - r0), 64'(1));
    chk("single_owner", 64'(rown(rsp_owner.size() - 1)), 64'(r));
    lat = rsp_cyc_last - gcyc(n0);
    d   = rsp_seen;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [13:0] d;
    int          lat, g0, r0;
    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    pdata[0]  = '0;
    pdata[1]  = '0;

    for (int s = 0; s < 8; s++) begin
      for (int i = 0; i < 32; i++) begin
        probe_sel = 3'(s);
        probe_in  = 5'(i);
        #1;
        chk("bank_table", 64'(probe_out), (s < 7) ? 64'(sbox_ref[s][i]) : 64'(0));
      end
    end

    @(posedge clk);
    #1;
    repeat (3) cycle();
    chk("reset_sb_sel", 64'(sb_sel), 64'(0));
    chk("reset_rsp_data", 64'(rsp_data), 64'(0));
    rst_drv = 1'b1;
    cycle();

    do_single(0, 35'(5'h05) << 10, d, lat);
    chk("sbox3_in05", 64'(d[5:4]), 64'(2'h3));
    chk("latency", 64'(lat), 64'(8));
    do_single(1, 35'(5'h00) << 10, d, lat);
    chk("sbox3_in00", 64'(d[5:4]), 64'(2'h2));
    do_single(0, 35'(5'h1f) << 10, d, lat);
    chk("sbox3_in1f", 64'(d[5:4]), 64'(2'h1));

    rst_drv = 1'b0;
    repeat (2) cycle();
    rst_drv = 1'b1;
    g0 = grant_id.size();
    r0 = rsp_cnt;
    pend = 2'b11;
    pdata[0] = rnd35();
    pdata[1] = rnd35();
    for (int i = 0; i < 40 && rsp_cnt < r0 + 2; i++) cycle();
    chk("simul_first", 64'(gid(g0)), 64'(0));
    chk("simul_second", 64'(gid(g0 + 1)), 64'(1));
    chk("simul_spacing", 64'(gcyc(g0 + 1) - gcyc(g0)), 64'(9));
    chk("simul_rsp_count", 64'(rsp_cnt - r0), 64'(2));
    chk("simul_owner0", 64'(rown(r0)), 64'(0));
    chk("simul_owner1", 64'(rown(r0 + 1)), 64'(1));

    g0 = grant_id.size();
    auto_rep = 1'b1;
    pend = 2'b11;
    pdata[0] = rnd35();
    pdata[1] = rnd35();
    for (int i = 0; i < 80 && grant_id.size() < g0 + 6; i++) cycle();
    auto_rep = 1'b0;
    pend = '0;
    for (int i = 0; i < 6; i++) begin
      chk("cont_order", 64'(gid(g0 + i)), 64'(i % 2));
      if (i > 0) chk("cont_spacing", 64'(gcyc(g0 + i) - gcyc(g0 + i - 1)), 64'(9));
    end
    repeat (12) cycle();

    g0 = grant_id.size();
    pend[0]  = 1'b1;
    pdata[0] = rnd35();
    for (int i = 0; i < 20 && grant_id.size() == g0; i++) cycle();
    chk("mid_grant", 64'(grant_id.size()), 64'(g0 + 1));
    repeat (3) cycle();
    pend    = '0;
    rst_drv = 1'b0;
    cycle();
    rst_drv = 1'b1;
    r0 = rsp_cnt;
    cycle();
    chk("post_reset_sb_sel", 64'(sb_sel), 64'(0));
    chk("post_reset_sb_in", 64'(sb_in), 64'(0));
    repeat (11) cycle();
    chk("dropped_no_rsp", 64'(rsp_cnt - r0), 64'(0));
    g0 = grant_id.size();
    pend = 2'b11;
    pdata[0] = rnd35();
    pdata[1] = rnd35();
    for (int i = 0; i < 40 && rsp_cnt < r0 + 2; i++) cycle();
    chk("reissue_ptr0", 64'(gid(g0)), 64'(0));
    chk("reissue_rsp_count", 64'(rsp_cnt - r0), 64'(2));

    r0 = rsp_cnt;
    rand_mode = 1'b1;
    for (int i = 0; i < 4000 && rsp_cnt < r0 + 200; i++) cycle();
    rand_mode = 1'b0;
    chk("random_rsp_count", 64'((rsp_cnt - r0 >= 200) ? 200 : rsp_cnt - r0), 64'(200));
    pend = '0;
    repeat (12) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
